// File: rtl/spi_rdid_slave.sv
// SPI flash-side responder for the RDID (0x9F) command, mode 0.
// The SPI pins are oversampled by clk and are never used as clocks.
module spi_rdid_slave #(
    parameter logic [7:0] MANUF_ID    = 8'h20,
    parameter logic [7:0] MEM_TYPE    = 8'h20,
    parameter logic [7:0] MEM_CAP     = 8'h15,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       rdid_done,
    output logic       bad_cmd,
    output logic       busy
);

    localparam logic [7:0]  RDID_CMD = 8'h9F;
    localparam logic [23:0] JEDEC_ID = {MANUF_ID, MEM_TYPE, MEM_CAP};

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_rise;

    logic [6:0]  cmd_shift;
    logic [7:0]  cmd_next;
    logic [2:0]  bit_cnt;
    logic [23:0] id_shift;
    logic [4:0]  resp_cnt;
    logic        first_fall;
    logic        cs_armed;
    logic        cmd_done;
    logic        resp_wrap;

    // Synchronizers reset to the bus idle levels so no false edge follows reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop in the chain sample the old value.
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // SPI clock edges only count while the synced chip select is asserted.
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;

    assign cmd_next  = {cmd_shift, mosi_s};
    assign resp_wrap = (state == RESP) && sclk_rise && (resp_cnt == 5'd23);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_next = state;
        cmd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_armed && !cs_s) state_next = CMD;
            end
            CMD: begin
                if (sclk_rise && (bit_cnt == 3'd7)) begin
                    cmd_done   = 1'b1;
                    state_next = (cmd_next == RDID_CMD) ? RESP : IGNORE;
                end
            end
            RESP, IGNORE: ;
            default: state_next = IDLE;
        endcase
        // Chip-select release aborts everything, including a completing command byte.
        if (cs_rise) begin
            state_next = IDLE;
            cmd_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'h00;
            rdid_done   <= 1'b0;
            bad_cmd     <= 1'b0;
            cmd_shift   <= '0;
            bit_cnt     <= '0;
            id_shift    <= '0;
            resp_cnt    <= '0;
            first_fall  <= 1'b0;
            cs_armed    <= 1'b0;
        end else begin
            cmd_valid   <= cmd_done;
            bad_cmd     <= cmd_done && (cmd_next != RDID_CMD);
            rdid_done   <= resp_wrap && !cs_rise;
            spi_miso_oe <= (state_next == RESP);
            // A new transfer needs CS seen high in IDLE before it is seen low.
            cs_armed    <= (state_next == IDLE) && (cs_armed || cs_s);

            if (cmd_done) cmd_byte <= cmd_next;

            if (state_next == IDLE || state_next == IGNORE) begin
                cmd_shift  <= '0;
                bit_cnt    <= '0;
                resp_cnt   <= '0;
                spi_miso   <= 1'b0;
                first_fall <= 1'b0;
            end else if (state == CMD) begin
                if (sclk_rise) begin
                    cmd_shift <= cmd_next[6:0];
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                if (cmd_done) begin
                    id_shift   <= JEDEC_ID;
                    resp_cnt   <= '0;
                    first_fall <= 1'b1;
                end
            end else if (state == RESP) begin
                if (sclk_fall) begin
                    if (first_fall) begin
                        spi_miso   <= id_shift[23];
                        first_fall <= 1'b0;
                    end else begin
                        id_shift <= {id_shift[22:0], 1'b0};
                        spi_miso <= id_shift[22];
                    end
                end
                // Reload on the 24th rise so the next fall restarts the ID with no gap.
                if (sclk_rise) begin
                    if (resp_cnt == 5'd23) begin
                        resp_cnt   <= '0;
                        id_shift   <= JEDEC_ID;
                        first_fall <= 1'b1;
                    end else begin
                        resp_cnt <= resp_cnt + 5'd1;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/spi_rdid_slave.md
Name: spi_rdid_slave

Overview:
- Single-clock SPI flash-side responder for the READ IDENTIFICATION (RDID, 0x9F) command.
- Sits directly downstream of the SPI master on the SPI bus: consumes its SPI clock, chip select and MOSI; produces MISO carrying the 3-byte JEDEC ID.
- Used as the on-chip / bench-side flash stand-in so the RDID master can be exercised end-to-end.
- SPI pins are oversampled by the system clock (SPI mode 0) and are never used as clocks.

Parameters:
- MANUF_ID, 8'h20, manufacturer ID byte (first byte out)
- MEM_TYPE, 8'h20, memory type byte (second byte out)
- MEM_CAP, 8'h15, memory capacity byte (third byte out)
- SYNC_STAGES, 2, synchronizer flops on spi_clk, spi_cs_n and spi_mosi (minimum 2)

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- spi_clk  input  1  SPI clock from master; idles low (mode 0)
- spi_cs_n  input  1  chip select from master, active low
- spi_mosi  input  1  serial data from master, MSB first
- spi_miso  output  1  serial data to master, MSB first
- spi_miso_oe  output  1  MISO drive enable; 0 = high-Z on pad
- cmd_valid  output  1  one-clk pulse when a full command byte has been received
- cmd_byte  output  8  last received command byte; held until next cmd_valid
- rdid_done  output  1  one-clk pulse when the 24th ID bit has been sampled by the master
- bad_cmd  output  1  one-clk pulse when the received command is not 0x9F
- busy  output  1  1 whenever the state is not IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; spi_miso=0, spi_miso_oe=0, cmd_valid=0, cmd_byte=8'h00, rdid_done=0, bad_cmd=0, busy=0; bit counters=0; synchronizers load idle levels (spi_clk=0, spi_cs_n=1, spi_mosi=0).
- Input path: spi_clk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops, then one edge-detect register. A rise, fall or CS edge is therefore detected SYNC_STAGES+1 clk after the pin edge.
- Spi_clk frequency must be ≤ clk/8; faster clocks are out of scope.
- States and transitions:
  - IDLE: spi_miso_oe=0. Synchronized spi_cs_n=0 -> CMD with bit_cnt=0.
  - CMD: on each detected spi_clk rise, shift synced MOSI into cmd_shift (MSB first) and increment bit_cnt. On the 8th rise:
    - load cmd_byte and pulse cmd_valid on the next clk.
    - byte == 8'h9F -> RESP: load id_shift={MANUF_ID,MEM_TYPE,MEM_CAP}, resp_cnt=0.
    - any other byte -> IGNORE, with bad_cmd pulsed together with cmd_valid.
  - RESP: spi_miso_oe=1.
    - On the first detected spi_clk fall after entry, spi_miso=id_shift[23].
    - On each later detected fall, shift left and drive the next bit.
    - On each detected rise, increment resp_cnt; when resp_cnt reaches 24, pulse rdid_done and reload id_shift. The ID repeats while CS stays low; wrap is seamless with no gap bit.
    - spi_miso changes only one clk after a detected fall, never near a rise.
  - IGNORE: spi_miso_oe=0, spi_miso=0; all spi_clk edges ignored until CS rises.
- CS deassert: a detected spi_cs_n rise in any state -> IDLE on the same clk.
  - spi_miso_oe=0, spi_miso=0, counters cleared.
  - No rdid_done or cmd_valid is generated for a partial transfer.
  - A CS rise coinciding with the 8th-rise detection aborts; the abort wins and no cmd_valid is produced.
- A spi_clk edge detected while synced CS is high is ignored.
- Async reset mid-transfer returns to IDLE immediately. After release, a new transfer is recognized only after a synchronized CS high-to-low sequence: IDLE requires synced spi_cs_n=1 for at least one clk before accepting CS low.
- The block generates no pulse in IDLE.
- cmd_valid, bad_cmd and rdid_done are mutually exclusive except the documented cmd_valid+bad_cmd pair.

Test Plan:
- Reset: hold reset=0 with random pins toggling -> spi_miso_oe=0, busy=0, cmd_byte=8'h00, no pulses; release -> still IDLE until CS falls.
- Nominal RDID at clk/8: CS low, shift 0x9F, clock 24 more bits -> cmd_valid once with cmd_byte=8'h9F; master captures 24'h202015; rdid_done one pulse; CS high -> spi_miso_oe=0 within SYNC_STAGES+2 clk.
- Wrap: 0x9F then 48 bits -> 24'h202015 received twice; rdid_done pulses exactly twice.
- Bad command: shift 0x03 then 16 clocks -> cmd_valid plus bad_cmd one pulse; cmd_byte=8'h03; spi_miso_oe stays 0; no rdid_done.
- Abort: CS high after 5 command bits, then a full 0x9F transfer -> first transfer gives no cmd_valid; second returns 24'h202015, proving counters were cleared.
- Mid-response reset: pulse reset=0 during response bit 10 -> outputs at reset values immediately; next full RDID transfer returns 24'h202015.
